dmem_responder: RTL and testbench

Responder side of the data-memory interface driven by the processor datapath. Accepts single-word load/store requests over a req/ack handshake, serves them from an on-chip word RAM or a small memory-mapped I/O window after a configurable number of wait states, and returns read data with a one-cycle acknowledge. It replaces the zero-latency data memory so the core can be exercised against realistic memory latency.

---
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack load/store port backed by a word RAM and a
// small MMIO window (LEDs, cycle counter, ID), with WAIT wait states per access.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WAIT       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic [7:0]  leds
);

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [31:0] ID_VALUE = 32'h4D495053;
  localparam logic [2:0]  WAIT_CNT = 3'(WAIT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cyc_q, cyc_d;
  logic [7:0]  leds_q, leds_d;
  logic [31:0] mem [DEPTH];

  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic                  acc_err;
  logic                  commit;
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  unused_addr_bits;

  function automatic logic decode_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31] && (a[3:2] == 2'b11));
  endfunction

  // State and request-latch registers; reset discards any latched request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      cyc_q   <= 32'h0;
      leds_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cyc_q   <= cyc_d;
      leds_q  <= leds_d;
    end
  end

  // Next-state logic and request capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = WAIT_CNT;
          state_d = (WAIT_CNT == 3'd0) ? S_RESP : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Commit-edge datapath; with zero wait states the access commits straight from IDLE
  always_comb begin
    acc_we    = (state_q == S_IDLE) ? we    : we_q;
    acc_addr  = (state_q == S_IDLE) ? addr  : addr_q;
    acc_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
    acc_err   = decode_err(acc_addr);
    commit    = (state_d == S_RESP) && (state_q != S_RESP);
    ram_idx   = acc_addr[DEPTH_LOG2+1:2];
    ram_we    = commit && !reset && acc_we && !acc_err && !acc_addr[31];
    ack_d     = commit;
    err_d     = commit && acc_err;
    rdata_d   = rdata_q;
    leds_d    = leds_q;
    cyc_d     = cyc_q + 32'd1;
    if (commit) begin
      if (acc_err) begin
        rdata_d = 32'h0;
      end else if (!acc_addr[31]) begin
        if (!acc_we) rdata_d = mem[ram_idx];
        else         rdata_d = rdata_q;
      end else begin
        case (acc_addr[3:2])
          2'b00: begin
            if (acc_we) leds_d  = acc_wdata[7:0];
            else        rdata_d = {24'h000000, leds_q};
          end
          2'b01: begin
            if (acc_we) cyc_d   = acc_wdata;
            else        rdata_d = cyc_q;
          end
          2'b10: begin
            if (!acc_we) rdata_d = ID_VALUE;
            else         rdata_d = rdata_q;
          end
          default: rdata_d = 32'h0;
        endcase
      end
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Word RAM, deliberately not reset
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= acc_wdata;
  end

  assign unused_addr_bits = ^acc_addr[30:DEPTH_LOG2+2];

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign leds  = leds_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench: four responders with WAIT = 1, 0, 7, 3 checked
// against a behavioural memory/MMIO model driven by request commit cycles.
module tb_dmem_responder;

  localparam logic [31:0] ID = 32'h4D495053;

  logic        clk = 1'b0;
  logic [3:0]  rst;
  logic [3:0]  req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack   [4];
  logic        err   [4];
  logic [31:0] rdata [4];
  logic [7:0]  leds  [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] m_mem   [4][64];
  logic        m_known [4][64];
  logic [7:0]  m_leds  [4];
  logic [31:0] m_bval  [4];
  int          m_bcyc  [4];

  int          o_lat [4];
  logic [31:0] o_rd  [4];
  logic        o_err [4];
  int          o_cyc [4];
  int          o_spur;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_LOG2(6), .WAIT(1)) u0 (.clk(clk), .reset(rst[0]), .req(req[0]), .we(we),
    .addr(addr), .wdata(wdata), .ack(ack[0]), .rdata(rdata[0]), .err(err[0]), .leds(leds[0]));
  dmem_responder #(.DEPTH_LOG2(6), .WAIT(0)) u1 (.clk(clk), .reset(rst[1]), .req(req[1]), .we(we),
    .addr(addr), .wdata(wdata), .ack(ack[1]), .rdata(rdata[1]), .err(err[1]), .leds(leds[1]));
  dmem_responder #(.DEPTH_LOG2(6), .WAIT(7)) u2 (.clk(clk), .reset(rst[2]), .req(req[2]), .we(we),
    .addr(addr), .wdata(wdata), .ack(ack[2]), .rdata(rdata[2]), .err(err[2]), .leds(leds[2]));
  dmem_responder #(.DEPTH_LOG2(6), .WAIT(3)) u3 (.clk(clk), .reset(rst[3]), .req(req[3]), .we(we),
    .addr(addr), .wdata(wdata), .ack(ack[3]), .rdata(rdata[3]), .err(err[3]), .leds(leds[3]));

  function automatic int wv(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      2:       return 7;
      default: return 3;
    endcase
  endfunction

  // Behavioural model of one access committed at clock edge number c
  task automatic model_access(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                              input int c, output logic [31:0] r, output logic e, output logic rchk);
    logic [5:0] idx;
    idx  = a[7:2];
    r    = 32'h0;
    e    = 1'b0;
    rchk = !w;
    if (a[1:0] != 2'b00) begin
      e = 1'b1; rchk = 1'b1;
    end else if (!a[31]) begin
      if (w) begin m_mem[i][idx] = d; m_known[i][idx] = 1'b1; end
      else begin r = m_mem[i][idx]; rchk = m_known[i][idx]; end
    end else begin
      case (a[3:2])
        2'b00: if (w) m_leds[i] = d[7:0]; else r = {24'h0, m_leds[i]};
        2'b01: if (w) begin m_bval[i] = d; m_bcyc[i] = c; end
               else r = m_bval[i] + 32'(c - 1 - m_bcyc[i]);
        2'b10: r = ID;
        default: begin e = 1'b1; rchk = 1'b1; end
      endcase
    end
  endtask

  // One-cycle req pulse to the masked instances, then observe ten cycles
  task automatic drive_txn(input logic [3:0] mask, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = mask; we = w; addr = a; wdata = d;
    for (int i = 0; i < 4; i++) o_lat[i] = 0;
    o_spur = 0;
    @(negedge clk);
    req = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) begin
          if (mask[i] && o_lat[i] == 0) begin
            o_lat[i] = k; o_rd[i] = rdata[i]; o_err[i] = err[i]; o_cyc[i] = cyc;
          end else begin
            o_spur++;
          end
        end else if (err[i]) begin
          o_spur++;
        end
      end
      if (k < 10) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 4'hF; req = 4'h0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ack[i] !== 1'b0 || err[i] !== 1'b0 || rdata[i] !== 32'h0 || leds[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset inst%0d ack=%b err=%b rdata=%h leds=%h, want all zero", i, ack[i], err[i], rdata[i], leds[i]);
      end
      m_leds[i] = 8'h00; m_bval[i] = 32'h0; m_bcyc[i] = cyc;
      for (int j = 0; j < 64; j++) m_known[i][j] = 1'b0;
    end
    rst = 4'h0;
  endtask

  task automatic test_ram_basic();
    logic [31:0] r; logic e, rc;
    drive_txn(4'hF, 1'b1, 32'h10, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      model_access(i, 1'b1, 32'h10, 32'hDEADBEEF, o_cyc[i], r, e, rc);
      checks++;
      if (o_lat[i] != wv(i) + 1 || o_err[i] !== 1'b0) begin
        errors++; $display("FAIL store_lat inst%0d lat=%0d err=%b, want %0d 0", i, o_lat[i], o_err[i], wv(i) + 1);
      end
    end
    drive_txn(4'hF, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      model_access(i, 1'b0, 32'h10, 32'h0, o_cyc[i], r, e, rc);
      checks++;
      if (o_lat[i] != wv(i) + 1 || o_rd[i] !== 32'hDEADBEEF || o_err[i] !== 1'b0) begin
        errors++;
        $display("FAIL load_ram inst%0d lat=%0d rdata=%h err=%b, want %0d deadbeef 0", i, o_lat[i], o_rd[i], o_err[i], wv(i) + 1);
      end
    end
    checks++;
    if (o_spur != 0) begin errors++; $display("FAIL spurious_ack got %0d want 0", o_spur); end
  endtask

  task automatic test_mmio();
    logic [31:0] r; logic e, rc;
    drive_txn(4'b0001, 1'b1, 32'h80000000, 32'h000001A5);
    model_access(0, 1'b1, 32'h80000000, 32'h000001A5, o_cyc[0], r, e, rc);
    checks++;
    if (leds[0] !== 8'hA5 || o_err[0] !== 1'b0) begin
      errors++; $display("FAIL led_store leds=%h err=%b, want a5 0", leds[0], o_err[0]);
    end
    drive_txn(4'b0001, 1'b0, 32'h80000000, 32'h0);
    checks++;
    if (o_rd[0] !== 32'h000000A5) begin errors++; $display("FAIL led_load got %h want 000000a5", o_rd[0]); end
    drive_txn(4'b0001, 1'b0, 32'h80000008, 32'h0);
    checks++;
    if (o_rd[0] !== ID || o_err[0] !== 1'b0) begin errors++; $display("FAIL id_load got %h err=%b want %h 0", o_rd[0], o_err[0], ID); end
    drive_txn(4'b0001, 1'b1, 32'h80000008, 32'h11111111);
    checks++;
    if (o_err[0] !== 1'b0 || o_lat[0] != 2) begin errors++; $display("FAIL id_store err=%b lat=%0d want 0 2", o_err[0], o_lat[0]); end
    drive_txn(4'b0001, 1'b0, 32'h8000000C, 32'h0);
    checks++;
    if (o_rd[0] !== 32'h0 || o_err[0] !== 1'b1) begin errors++; $display("FAIL unmapped got %h err=%b want 0 1", o_rd[0], o_err[0]); end
  endtask

  task automatic test_counter();
    int c1;
    drive_txn(4'b0001, 1'b1, 32'h80000004, 32'hFFFFFFFE);
    c1 = o_cyc[0];
    m_bval[0] = 32'hFFFFFFFE; m_bcyc[0] = c1;
    drive_txn(4'b0001, 1'b0, 32'h80000004, 32'h0);
    checks++;
    if (o_rd[0] !== 32'hFFFFFFFE + 32'(o_cyc[0] - 1 - c1) || o_rd[0] > 32'd64) begin
      errors++; $display("FAIL counter_wrap got %h want %h", o_rd[0], 32'hFFFFFFFE + 32'(o_cyc[0] - 1 - c1));
    end
  endtask

  // Hold req on one instance across three accesses and measure ack spacing
  task automatic test_back_to_back(input int n, input logic [31:0] a);
    int ac [3]; logic [31:0] ar [3]; int got, t0;
    got = 0;
    @(negedge clk);
    we = 1'b0; addr = a; req[n] = 1'b1; t0 = cyc;
    for (int k = 0; k < 40 && got < 3; k++) begin
      @(negedge clk);
      if (ack[n]) begin
        ac[got] = cyc; ar[got] = rdata[n]; got++;
        if (got == 3) req[n] = 1'b0;
      end
    end
    req[n] = 1'b0;
    checks++;
    if (got != 3) begin
      errors++; $display("FAIL b2b_count inst%0d got %0d acks want 3", n, got);
    end else begin
      checks++;
      if (ac[0] - t0 != wv(n) + 1 || ac[1] - ac[0] != wv(n) + 2 || ac[2] - ac[1] != wv(n) + 2) begin
        errors++;
        $display("FAIL b2b_spacing inst%0d got %0d %0d %0d want %0d %0d %0d", n, ac[0] - t0, ac[1] - ac[0],
                 ac[2] - ac[1], wv(n) + 1, wv(n) + 2, wv(n) + 2);
      end
      checks++;
      if (a[2] ? (ar[1] - ar[0] != 32'(wv(n) + 2) || ar[2] - ar[1] != 32'(wv(n) + 2)) : (ar[0] !== ID || ar[2] !== ID)) begin
        errors++; $display("FAIL b2b_data inst%0d got %h %h %h", n, ar[0], ar[1], ar[2]);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] r; logic e, rc;
    drive_txn(4'hF, 1'b1, 32'h12, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      model_access(i, 1'b1, 32'h12, 32'h12345678, o_cyc[i], r, e, rc);
      checks++;
      if (o_lat[i] != wv(i) + 1 || o_err[i] !== 1'b1 || o_rd[i] !== 32'h0) begin
        errors++; $display("FAIL misaligned inst%0d lat=%0d err=%b rdata=%h want %0d 1 0", i, o_lat[i], o_err[i], o_rd[i], wv(i) + 1);
      end
    end
    drive_txn(4'hF, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_rd[i] !== 32'hDEADBEEF) begin errors++; $display("FAIL misaligned_keep inst%0d got %h want deadbeef", i, o_rd[i]); end
    end
  endtask

  // Reset of the WAIT=3 instance during WAIT, at the commit edge and at accept
  task automatic test_reset_abort();
    logic [31:0] r; logic e, rc; int rk, seen;
    drive_txn(4'b1000, 1'b1, 32'h20, 32'hA0A0A0A0);
    model_access(3, 1'b1, 32'h20, 32'hA0A0A0A0, o_cyc[3], r, e, rc);
    checks++;
    if (o_lat[3] != 4) begin errors++; $display("FAIL early_drop lat=%0d want 4", o_lat[3]); end
    for (int s = 0; s < 3; s++) begin
      rk = (s == 0) ? 1 : ((s == 1) ? 3 : 0);
      seen = 0;
      @(negedge clk);
      we = 1'b1; addr = 32'h20; wdata = 32'h5A5A0000 + 32'(s); req[3] = 1'b1;
      if (rk == 0) rst[3] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
        @(negedge clk);
        if (k == 1) req[3] = 1'b0;
        if (rst[3]) begin
          rst[3] = 1'b0; m_leds[3] = 8'h00; m_bval[3] = 32'h0; m_bcyc[3] = cyc;
        end
        if (k == rk) rst[3] = 1'b1;
        if (ack[3]) seen++;
      end
      checks++;
      if (seen != 0 || rdata[3] !== 32'h0) begin
        errors++; $display("FAIL reset_abort s%0d acks=%0d rdata=%h want 0 0", s, seen, rdata[3]);
      end
      drive_txn(4'b1000, 1'b0, 32'h20, 32'h0);
      checks++;
      if (o_rd[3] !== 32'hA0A0A0A0) begin errors++; $display("FAIL reset_nostore s%0d got %h want a0a0a0a0", s, o_rd[3]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] r, a, d, t; logic e, rc, w; int kind;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      t = $urandom;
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (kind < 6)      a = {1'b0, 23'($urandom), 2'b00, 4'($urandom_range(0, 15)), 2'b00};
      else if (kind < 9) a = {1'b1, 27'($urandom), 2'($urandom_range(0, 3)), 2'b00};
      else               a = {t[31:2], 2'($urandom_range(1, 3))};
      drive_txn(4'hF, w, a, d);
      for (int i = 0; i < 4; i++) begin
        model_access(i, w, a, d, o_cyc[i], r, e, rc);
        checks++;
        if (o_lat[i] != wv(i) + 1 || o_err[i] !== e || (rc && o_rd[i] !== r) || leds[i] !== m_leds[i]) begin
          errors++;
          $display("FAIL random n%0d inst%0d we=%b addr=%h lat=%0d err=%b rdata=%h leds=%h want %0d %b %h %h",
                   n, i, w, a, o_lat[i], o_err[i], o_rd[i], leds[i], wv(i) + 1, e, r, m_leds[i]);
        end
      end
      checks++;
      if (o_spur != 0) begin errors++; $display("FAIL random_spurious n%0d got %0d want 0", n, o_spur); end
    end
  endtask

  initial begin
    test_reset();
    test_ram_basic();
    test_mmio();
    test_counter();
    test_back_to_back(1, 32'h80000008);
    test_back_to_back(2, 32'h80000008);
    test_back_to_back(0, 32'h80000004);
    test_misaligned();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
